dpb_axi_rd_fetch: RTL and testbench

AXI3 read initiator that fetches a rectangular block of reference-picture samples from the DPB in DDR and streams the returned 64-bit beats to a consumer (inter-prediction reference loader). It issues one INCR burst per picture row, keeps several bursts outstanding, and reserves output-FIFO space before each address request, so it never back-pressures the R channel. It is the master-side counterpart of the DDR/AXI slave model in the testbench.

---
 rtl/dpb_axi_rd_fetch_pkg.sv | 43 ++++
 rtl/dpb_axi_rd_fetch_sync_fifo_65.sv | 66 ++++++
 rtl/dpb_axi_rd_fetch.sv | 210 +++++++++++++++++++++
 tb/tb_dpb_axi_rd_fetch.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpb_axi_rd_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpb_axi_rd_fetch_pkg
// Description : Shared constants for the DPB reference-block AXI read fetcher
//               (luma row stride, AXI encodings, DPB base addresses, FSM type).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DPB_AXI_RD_FETCH_DEFS
`define DPB_AXI_RD_FETCH_DEFS
// log2 of the luma row stride in bytes; one picture row per 4 KiB
`define MAX_X_BITS 12
`endif

package dpb_axi_rd_fetch_pkg;

   localparam int         c_max_x_bits   = `MAX_X_BITS;

   // 64-bit beats, incrementing bursts
   localparam logic [2:0] c_axi_size_8b  = 3'b011;
   localparam logic [1:0] c_axi_burst_incr = 2'b01;

   // Decoded picture buffer slots in DDR, used by callers to form req_addr
   localparam logic [31:0] DDR_BASE_DPB0 = 32'h2000_0000;
   localparam logic [31:0] DDR_BASE_DPB1 = 32'h2090_0000;
   localparam logic [31:0] DDR_BASE_DPB2 = 32'h2120_0000;
   localparam logic [31:0] DDR_BASE_DPB3 = 32'h21B0_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } fetch_state_e;

   // Byte address of picture row 'row' of a block starting at 'base'
   function automatic logic [31:0] row_addr(input logic [31:0] base,
                                            input logic [8:0]  row);
      return base + (32'(row) << c_max_x_bits);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dpb_axi_rd_fetch_sync_fifo_65.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_65
// Description : Single-clock FIFO of 65-bit words (64 data + last tag) with
//               registered push, first-word-fall-through output, occupancy.
// Revision    : 1.0 - initial release
// ============================================================================

module sync_fifo_65 #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [64:0]              i_push_data,
   input  logic                     i_pop,
   output logic [64:0]              o_pop_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int             c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0]  c_full = DEPTH[c_aw:0];

   logic [64:0]     r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            w_pop;
   logic            w_push;

   assign w_pop  = i_pop && (r_count != '0);
   // a full FIFO still accepts a word when one leaves in the same cycle
   assign w_push = i_push && ((r_count != c_full) || w_pop);

   // Storage array; contents need no reset since occupancy gates the output
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers and occupancy, cleared immediately on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_aw + 1)'(1);
            2'b01:   r_count <= r_count - (c_aw + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid    = (r_count != '0);
   assign o_pop_data = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/dpb_axi_rd_fetch.sv
`default_nettype none
// ============================================================================
// Module      : dpb_axi_rd_fetch
// Description : AXI3 read initiator fetching a rectangular reference block,
//               one INCR burst per row, with output-FIFO space reserved
//               before each AR so the R channel is never back-pressured.
// Revision    : 1.0 - initial release
// ============================================================================

module dpb_axi_rd_fetch
   import dpb_axi_rd_fetch_pkg::*;
#(
   parameter int         MAX_OUTSTANDING = 4,
   parameter int         FIFO_DEPTH      = 64,
   parameter logic [5:0] ARID_VAL        = 6'd0
) (
   input  logic        m_axi_clk,
   input  logic        m_axi_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [4:0]  req_beats,
   input  logic [7:0]  req_rows,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [3:0]  m_axi_arlen,
   output logic [5:0]  m_axi_arid,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic [1:0]  m_axi_arlock,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [63:0] m_axi_rdata,
   input  logic        m_axi_rlast,
   input  logic [5:0]  m_axi_rid,
   input  logic [1:0]  m_axi_rresp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        err
);

   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic               r_rready;
   logic               r_arvalid;
   logic [31:0]        r_araddr;
   logic [3:0]         r_arlen;
   logic [31:0]        r_base;
   logic [4:0]         r_beats;
   logic [8:0]         r_rows;
   logic [8:0]         r_row_cnt;
   logic [8:0]         r_rows_ret;
   logic [3:0]         r_outstanding;
   logic [3:0]         w_out_nxt;
   logic [c_cnt_w-1:0] r_reserved;
   logic [c_cnt_w-1:0] w_res_nxt;
   logic               r_err;
   logic               w_req_ready;
   logic               w_accept;
   logic               w_issue;
   logic               w_ar_hs;
   logic               w_r_hs;
   logic               w_r_tracked;
   logic               w_credit_ok;
   logic               w_space_ok;
   logic               w_last_row_issue;
   logic               w_last_row_ret;
   logic               w_tag_last;
   logic [c_cnt_w-1:0] w_fifo_count;
   logic [64:0]        w_fifo_out;
   logic               w_unused;

   assign w_ar_hs          = r_arvalid && m_axi_arready;
   assign w_r_hs           = m_axi_rvalid && r_rready;
   // beats with no burst on record are leftovers from before a reset
   assign w_r_tracked      = w_r_hs && (r_outstanding != 4'd0);
   assign w_credit_ok      = 32'(r_outstanding) < MAX_OUTSTANDING;
   assign w_space_ok       = (32'(w_fifo_count) + 32'(r_reserved) + 32'(r_beats))
                             <= FIFO_DEPTH;
   assign w_last_row_issue = (r_row_cnt == r_rows - 9'd1);
   assign w_last_row_ret   = (r_rows_ret == r_rows - 9'd1);
   assign w_tag_last       = m_axi_rlast && w_last_row_ret;

   // State register
   always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
      if (m_axi_rst) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state, request acceptance and AR issue decision
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = r_rready;
            if (req_valid && r_rready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_issue = !r_arvalid && w_credit_ok && w_space_ok;
            if (w_ar_hs && w_last_row_issue) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_r_tracked && m_axi_rlast && w_last_row_ret) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Credit counters: both increment and decrement may land in one cycle
   always_comb begin
      w_out_nxt = r_outstanding;
      w_res_nxt = r_reserved;
      if (w_ar_hs) begin
         w_out_nxt = w_out_nxt + 4'd1;
         w_res_nxt = w_res_nxt + c_cnt_w'(r_beats);
      end
      if (w_r_tracked && m_axi_rlast) w_out_nxt = w_out_nxt - 4'd1;
      if (w_r_tracked && (r_reserved != '0)) w_res_nxt = w_res_nxt - c_cnt_w'(1);
   end

   // Request latch, AR channel, row tracking, credits and error flag
   always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
      if (m_axi_rst) begin
         r_rready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_araddr      <= '0;
         r_arlen       <= '0;
         r_base        <= '0;
         r_beats       <= '0;
         r_rows        <= '0;
         r_row_cnt     <= '0;
         r_rows_ret    <= '0;
         r_outstanding <= '0;
         r_reserved    <= '0;
         r_err         <= 1'b0;
      end else begin
         r_rready      <= 1'b1;
         r_outstanding <= w_out_nxt;
         r_reserved    <= w_res_nxt;
         if (w_accept) begin
            r_base     <= {req_addr[31:3], 3'b000};
            r_beats    <= (req_beats == 5'd0) ? 5'd16 : req_beats;
            r_rows     <= (req_rows == 8'd0) ? 9'd256 : {1'b0, req_rows};
            r_row_cnt  <= '0;
            r_rows_ret <= '0;
         end
         if (w_issue) begin
            r_arvalid <= 1'b1;
            r_araddr  <= row_addr(r_base, r_row_cnt);
            r_arlen   <= 4'(r_beats - 5'd1);
         end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_row_cnt <= r_row_cnt + 9'd1;
         end
         if (w_r_tracked && m_axi_rlast) r_rows_ret <= r_rows_ret + 9'd1;
         if (w_r_hs && (m_axi_rresp != 2'b00)) r_err <= 1'b1;
      end
   end

   sync_fifo_65 #(
      .DEPTH       (FIFO_DEPTH)
   ) u_fifo (
      .clk         (m_axi_clk),
      .rst         (m_axi_rst),
      .i_push      (w_r_tracked),
      .i_push_data ({w_tag_last, m_axi_rdata}),
      .i_pop       (out_ready),
      .o_pop_data  (w_fifo_out),
      .o_valid     (out_valid),
      .o_count     (w_fifo_count)
   );

   assign req_ready     = w_req_ready;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arid    = ARID_VAL;
   assign m_axi_arsize  = c_axi_size_8b;
   assign m_axi_arburst = c_axi_burst_incr;
   assign m_axi_arlock  = 2'b00;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;
   assign m_axi_rready  = r_rready;
   assign out_data      = w_fifo_out[63:0];
   assign out_last      = w_fifo_out[64];
   assign busy          = (r_state != ST_IDLE);
   assign err           = r_err;

   // single-ID in-order slave, and bursts are always 8-byte aligned
   assign w_unused = ^{m_axi_rid, req_addr[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_dpb_axi_rd_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpb_axi_rd_fetch
// Description : Directed bench for dpb_axi_rd_fetch with an in-order AXI DDR
//               slave model and an expected-beat model of the block layout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_dpb_axi_rd_fetch;
   import dpb_axi_rd_fetch_pkg::*;

   localparam int c_max_out = 4;
   localparam int c_depth   = 64;

   logic        m_axi_clk = 1'b0;
   logic        m_axi_rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [4:0]  req_beats = '0;
   logic [7:0]  req_rows = '0;
   logic        m_axi_arvalid;
   logic        m_axi_arready = 1'b0;
   logic [31:0] m_axi_araddr;
   logic [3:0]  m_axi_arlen;
   logic [5:0]  m_axi_arid;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic [1:0]  m_axi_arlock;
   logic [3:0]  m_axi_arcache;
   logic [2:0]  m_axi_arprot;
   logic [3:0]  m_axi_arqos;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;
   logic [63:0] m_axi_rdata = '0;
   logic        m_axi_rlast = 1'b0;
   logic [5:0]  m_axi_rid = 6'd0;
   logic [1:0]  m_axi_rresp = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        out_last;
   logic        busy;
   logic        err;

   dpb_axi_rd_fetch #(
      .MAX_OUTSTANDING (c_max_out),
      .FIFO_DEPTH      (c_depth),
      .ARID_VAL        (6'd0)
   ) dut (
      .m_axi_clk     (m_axi_clk),
      .m_axi_rst     (m_axi_rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_beats     (req_beats),
      .req_rows      (req_rows),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arid    (m_axi_arid),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arqos   (m_axi_arqos),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rresp   (m_axi_rresp),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .err           (err)
   );

   always #5 m_axi_clk = ~m_axi_clk;

   int n_vec = 0;
   int n_err = 0;

   // slave and consumer behaviour knobs
   int          ar_duty = 100;
   int          r_duty = 100;
   bit          rnd_ready = 1'b0;
   logic        out_ready_fix = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   bit          watch_rready = 1'b0;

   logic [31:0] ar_addr_q[$];
   logic [3:0]  ar_len_q[$];
   logic [31:0] pend_addr[$];
   logic [3:0]  pend_len[$];
   int          r_idx = 0;
   int          model_out = 0;
   int          ovf_seen = 0;
   int          rready_low_seen = 0;
   logic [64:0] act_q[$];
   logic [64:0] exp_q[$];

   // DDR contents: every 8-byte word is derived from its own address
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'h5A5A_C3C3, a};
   endfunction

   // Record handshakes on every channel at the active edge
   always @(posedge m_axi_clk) begin
      if (m_axi_rst) begin
         model_out = 0;
      end else begin
         if (m_axi_arvalid && m_axi_arready) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(m_axi_arlen);
            pend_addr.push_back(m_axi_araddr);
            pend_len.push_back(m_axi_arlen);
            model_out++;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            if (m_axi_rlast) begin
               void'(pend_addr.pop_front());
               void'(pend_len.pop_front());
               r_idx = 0;
               if (model_out > 0) model_out--;
            end else begin
               r_idx++;
            end
         end
         if (model_out > c_max_out) ovf_seen++;
         if (watch_rready && !m_axi_rready) rready_low_seen++;
         if (out_valid && out_ready) act_q.push_back({out_last, out_data});
      end
   end

   // Drive slave responses and consumer ready away from the active edge
   always @(negedge m_axi_clk) begin
      logic [31:0] a;
      m_axi_arready = ($urandom_range(99) < ar_duty);
      if (pend_addr.size() != 0 && $urandom_range(99) < r_duty) begin
         a            = pend_addr[0] + 32'(r_idx * 8);
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = mem_word(a);
         m_axi_rlast  = (r_idx == int'(pend_len[0]));
         m_axi_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
      end else begin
         m_axi_rvalid = 1'b0;
         m_axi_rlast  = 1'b0;
         m_axi_rresp  = 2'b00;
      end
      out_ready = rnd_ready ? 1'($urandom_range(1)) : out_ready_fix;
   end

   task automatic expect_req(input logic [31:0] a, input logic [4:0] b, input logic [7:0] r);
      logic [31:0] base;
      logic        lst;
      int          nb;
      int          nr;
      base = {a[31:3], 3'b000};
      nb   = (b == 5'd0) ? 16 : int'(b);
      nr   = (r == 8'd0) ? 256 : int'(r);
      for (int row = 0; row < nr; row++) begin
         for (int bt = 0; bt < nb; bt++) begin
            lst = (row == nr - 1) && (bt == nb - 1);
            exp_q.push_back({lst, mem_word(base + (32'(row) << c_max_x_bits) + 32'(bt * 8))});
         end
      end
   endtask

   task automatic send_req(input logic [31:0] a, input logic [4:0] b, input logic [7:0] r,
                           output bit ok);
      int t = 0;
      ok = 1'b0;
      @(negedge m_axi_clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_beats = b;
      req_rows  = r;
      while (t < 3000) begin
         if (req_ready) begin
            @(posedge m_axi_clk);
            ok = 1'b1;
            break;
         end
         @(negedge m_axi_clk);
         t++;
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      int t = 0;
      while (act_q.size() < n && t < budget) begin
         @(negedge m_axi_clk);
         t++;
      end
      ok = (act_q.size() >= n);
   endtask

   task automatic clear_logs();
      act_q.delete();
      exp_q.delete();
      ar_addr_q.delete();
      ar_len_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge m_axi_clk);
      n_vec++;
      if ({m_axi_arvalid, m_axi_rready, req_ready, out_valid, out_last, busy, err} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outputs: actual=%b required=0000000",
                  {m_axi_arvalid, m_axi_rready, req_ready, out_valid, out_last, busy, err});
      end
      n_vec++;
      if ({m_axi_araddr, m_axi_arlen} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_ar: actual=%h required=0", {m_axi_araddr, m_axi_arlen});
      end
      m_axi_rst = 1'b0;
      @(negedge m_axi_clk);
      n_vec++;
      if ({req_ready, m_axi_rready} !== 2'b11) begin
         n_err++;
         $display("FAIL post_reset_ready: actual=%b required=11", {req_ready, m_axi_rready});
      end
   endtask

   task automatic test_single();
      bit ok;
      clear_logs();
      expect_req(32'h2090_0000, 5'd4, 8'd2);
      send_req(32'h2090_0000, 5'd4, 8'd2, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL single_accept: actual=timeout required=accept"); end
      wait_out(8, 500, ok);
      repeat (4) @(negedge m_axi_clk);
      n_vec++;
      if (ar_addr_q.size() != 2 || act_q.size() != 8) begin
         n_err++;
         $display("FAIL single_counts: actual ar=%0d beats=%0d required ar=2 beats=8",
                  ar_addr_q.size(), act_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         logic [35:0] got;
         logic [35:0] want;
         got  = (i < ar_addr_q.size()) ? {ar_addr_q[i], ar_len_q[i]} : 'x;
         want = {32'h2090_0000 + (32'(i) << c_max_x_bits), 4'd3};
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL single_ar%0d: actual=%h required=%h", i, got, want);
         end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL single_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
      n_vec++;
      if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
           m_axi_arprot, m_axi_arqos, busy} !== {6'd0, 3'b011, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL single_ar_consts_busy: actual=%h", {m_axi_arid, m_axi_arsize,
                  m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, busy});
      end
   endtask

   task automatic test_zero_beats();
      bit ok;
      clear_logs();
      expect_req(32'h0000_1003, 5'd0, 8'd1);
      send_req(32'h0000_1003, 5'd0, 8'd1, ok);
      wait_out(16, 500, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL zero_beats_count: actual=%0d required=16", act_q.size()); end
      n_vec++;
      if (ar_addr_q.size() != 1 || {ar_addr_q[0], ar_len_q[0]} !== {32'h0000_1000, 4'd15}) begin
         n_err++;
         $display("FAIL zero_beats_ar: actual n=%0d required addr=00001000 len=f", ar_addr_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL zero_beats_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      clear_logs();
      out_ready_fix = 1'b0;
      expect_req(32'h2000_0040, 5'd16, 8'd8);
      send_req(32'h2000_0040, 5'd16, 8'd8, ok);
      repeat (200) @(negedge m_axi_clk);
      n_vec++;
      if (ar_addr_q.size() != 4) begin
         n_err++;
         $display("FAIL stall_ar_count: actual=%0d required=4", ar_addr_q.size());
      end
      n_vec++;
      if (act_q.size() != 0 || busy !== 1'b1 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_state: actual beats=%0d busy=%b valid=%b required 0/1/1",
                  act_q.size(), busy, out_valid);
      end
      out_ready_fix = 1'b1;
      wait_out(128, 3000, ok);
      n_vec++;
      if (!ok || ar_addr_q.size() != 8) begin
         n_err++;
         $display("FAIL stall_resume: actual beats=%0d ar=%0d required 128/8", act_q.size(), ar_addr_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL stall_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      clear_logs();
      ar_duty = 25;
      r_duty = 25;
      rnd_ready = 1'b1;
      ovf_seen = 0;
      rready_low_seen = 0;
      watch_rready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [31:0] a;
         logic [4:0]  b;
         logic [7:0]  r;
         a = $urandom & 32'h3FFF_FFFF;
         b = 5'($urandom_range(16, 0));
         r = 8'($urandom_range(4, 1));
         expect_req(a, b, r);
         send_req(a, b, r, ok);
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL random_accept%0d: actual=timeout required=accept", k); end
      end
      wait_out(exp_q.size(), 40000, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL random_count: actual=%0d required=%0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL random_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
      n_vec++;
      if (ovf_seen != 0 || rready_low_seen != 0) begin
         n_err++;
         $display("FAIL random_credit: actual ovf=%0d rready_low=%0d required 0/0", ovf_seen, rready_low_seen);
      end
      watch_rready = 1'b0;
      rnd_ready = 1'b0;
      ar_duty = 100;
      r_duty = 100;
      repeat (10) @(negedge m_axi_clk);
   endtask

   task automatic test_err();
      bit ok;
      clear_logs();
      n_vec++;
      if (err !== 1'b0) begin n_err++; $display("FAIL err_before: actual=%b required=0", err); end
      err_addr = 32'h3000_0008;
      expect_req(32'h3000_0000, 5'd2, 8'd1);
      send_req(32'h3000_0000, 5'd2, 8'd1, ok);
      wait_out(2, 300, ok);
      @(negedge m_axi_clk);
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL err_set: actual=%b required=1", err); end
      err_addr = 32'hFFFF_FFFF;
      expect_req(32'h3000_1000, 5'd1, 8'd1);
      send_req(32'h3000_1000, 5'd1, 8'd1, ok);
      wait_out(3, 300, ok);
      repeat (3) @(negedge m_axi_clk);
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: actual=%b required=1", err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL err_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t = 0;
      clear_logs();
      r_duty = 0;
      send_req(32'h4000_0000, 5'd16, 8'd4, ok);
      while (ar_addr_q.size() < 2 && t < 100) begin
         @(negedge m_axi_clk);
         t++;
      end
      m_axi_rst = 1'b1;
      #1;
      n_vec++;
      if ({m_axi_arvalid, m_axi_rready, req_ready, out_valid, out_last, busy, err} !== 7'b0
          || {m_axi_araddr, m_axi_arlen} !== 36'h0) begin
         n_err++;
         $display("FAIL mid_reset_outputs: actual=%b %h required=0",
                  {m_axi_arvalid, m_axi_rready, req_ready, out_valid, out_last, busy, err},
                  {m_axi_araddr, m_axi_arlen});
      end
      repeat (2) @(negedge m_axi_clk);
      m_axi_rst = 1'b0;
      act_q.delete();
      r_duty = 100;
      t = 0;
      while (pend_addr.size() != 0 && t < 200) begin
         @(negedge m_axi_clk);
         t++;
      end
      repeat (3) @(negedge m_axi_clk);
      n_vec++;
      if (pend_addr.size() != 0 || act_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_discard: actual pend=%0d beats=%0d valid=%b busy=%b required 0/0/0/0",
                  pend_addr.size(), act_q.size(), out_valid, busy);
      end
      clear_logs();
      expect_req(32'h4000_0100, 5'd3, 8'd2);
      send_req(32'h4000_0100, 5'd3, 8'd2, ok);
      wait_out(6, 500, ok);
      n_vec++;
      if (!ok || ar_addr_q.size() != 2) begin
         n_err++;
         $display("FAIL mid_reset_new: actual beats=%0d ar=%0d required 6/2", act_q.size(), ar_addr_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [64:0] got;
         got = (i < act_q.size()) ? act_q[i] : 'x;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL mid_reset_beat%0d: actual=%h required=%h", i, got, exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_beats();
      test_stall();
      test_random();
      test_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: actual=no completion required=completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
